// File: rtl/module_input_conditioner.sv
// Synchronizes and debounces the raw Gray-code switches and pushbutton ahead of the Gray decoder,
// producing a clean code, a press-toggled decades select, and single-cycle event strobes.
module module_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_raw,
    input  logic       btn_raw,
    output logic [3:0] gray_code,
    output logic       show_decades,
    output logic       gray_changed,
    output logic       btn_pulse
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_e;

    // ------------------------------------------------------------------
    // Synchronizer chains
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] gray_sync_q;
    logic [SYNC_STAGES-1:0]      btn_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_sync_q <= '0;
            btn_sync_q  <= {SYNC_STAGES{BTN_IDLE}};
        end else begin
            gray_sync_q[0] <= gray_raw;
            btn_sync_q[0]  <= btn_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                gray_sync_q[i] <= gray_sync_q[i-1];
                btn_sync_q[i]  <= btn_sync_q[i-1];
            end
        end
    end

    logic [3:0] gray_s;
    logic       btn_s;

    assign gray_s = gray_sync_q[SYNC_STAGES-1];
    // XOR with the idle level makes pressed read as 1 for either board polarity.
    assign btn_s  = btn_sync_q[SYNC_STAGES-1] ^ BTN_IDLE;

    // ------------------------------------------------------------------
    // Bus debouncer: the four bits share one counter
    // ------------------------------------------------------------------
    logic [3:0]    gray_prev_q, gray_prev_d;
    logic [3:0]    gray_st_q,   gray_st_d;
    logic [CW-1:0] gray_cnt_q,  gray_cnt_d;
    logic          gray_chg_q,  gray_chg_d;

    always_comb begin
        gray_prev_d = gray_s;
        gray_st_d   = gray_st_q;
        gray_cnt_d  = gray_cnt_q;
        gray_chg_d  = 1'b0;
        if ((gray_s == gray_st_q) || (gray_s != gray_prev_q)) begin
            gray_cnt_d = '0;
        end else if (gray_cnt_q == CNT_MAX) begin
            gray_st_d  = gray_s;
            gray_cnt_d = '0;
            gray_chg_d = 1'b1;
        end else begin
            gray_cnt_d = gray_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_prev_q <= '0;
            gray_st_q   <= '0;
            gray_cnt_q  <= '0;
            gray_chg_q  <= 1'b0;
        end else begin
            gray_prev_q <= gray_prev_d;
            gray_st_q   <= gray_st_d;
            gray_cnt_q  <= gray_cnt_d;
            gray_chg_q  <= gray_chg_d;
        end
    end

    // ------------------------------------------------------------------
    // Button debouncer (normalized polarity, so history resets to not-pressed)
    // ------------------------------------------------------------------
    logic          btn_prev_q, btn_prev_d;
    logic          btn_st_q,   btn_st_d;
    logic [CW-1:0] btn_cnt_q,  btn_cnt_d;

    always_comb begin
        btn_prev_d = btn_s;
        btn_st_d   = btn_st_q;
        btn_cnt_d  = btn_cnt_q;
        if ((btn_s == btn_st_q) || (btn_s != btn_prev_q)) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q == CNT_MAX) begin
            btn_st_d  = btn_s;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b0;
            btn_st_q   <= 1'b0;
            btn_cnt_q  <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            btn_st_q   <= btn_st_d;
            btn_cnt_q  <= btn_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Button FSM: one toggle and one strobe per confirmed press
    // ------------------------------------------------------------------
    btn_state_e btn_state_q;
    logic       btn_pulse_q;
    logic       show_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_state_q <= RELEASED;
            btn_pulse_q <= 1'b0;
            show_q      <= 1'b0;
        end else begin
            btn_pulse_q <= 1'b0;
            case (btn_state_q)
                RELEASED: begin
                    if (btn_st_q) begin
                        btn_state_q <= PRESSED;
                        btn_pulse_q <= 1'b1;
                        show_q      <= ~show_q;
                    end
                end
                PRESSED: begin
                    if (!btn_st_q) begin
                        btn_state_q <= RELEASED;
                    end
                end
                default: btn_state_q <= RELEASED;
            endcase
        end
    end

    assign gray_code    = gray_st_q;
    assign gray_changed = gray_chg_q;
    assign btn_pulse    = btn_pulse_q;
    assign show_decades = show_q;

endmodule

// File: tb/tb_module_input_conditioner.sv
// Self-checking bench for module_input_conditioner: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a history-window reference model.
module tb_module_input_conditioner;

    localparam int DC = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_raw = 4'h0;
    logic       btn_raw = 1'b1;
    logic [3:0] gray_code;
    logic       show_decades;
    logic       gray_changed;
    logic       btn_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int gchg_cnt = 0;

    module_input_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_raw    (gray_raw),
        .btn_raw     (btn_raw),
        .gray_code   (gray_code),
        .show_decades(show_decades),
        .gray_changed(gray_changed),
        .btn_pulse   (btn_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples since reset; a level is accepted once the
    // synchronized view has shown it for DC+1 consecutive edges.
    logic [3:0] g_hist[$];
    bit         b_hist[$];
    logic [3:0] m_gray;
    bit         m_gchg, m_bst, m_bst_prev, m_pulse, m_show;

    function automatic logic [3:0] g_at(input int idx);
        if (idx < 0) return 4'h0;
        return g_hist[idx];
    endfunction

    function automatic bit b_at(input int idx);
        if (idx < 0) return 1'b0;
        return b_hist[idx];
    endfunction

    task automatic model_reset();
        g_hist.delete();
        b_hist.delete();
        m_gray = 4'h0;
        m_gchg = 1'b0;
        m_bst = 1'b0;
        m_bst_prev = 1'b0;
        m_pulse = 1'b0;
        m_show = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] g, input logic b);
        int e;
        bit g_stable, b_stable, bv;
        logic [3:0] gv;
        g_hist.push_back(g);
        b_hist.push_back(!b);
        e = g_hist.size() - 1;
        gv = g_at(e - SS);
        g_stable = 1'b1;
        for (int j = 1; j <= DC; j++) if (g_at(e - SS - j) != gv) g_stable = 1'b0;
        m_gchg = 1'b0;
        if (g_stable && gv != m_gray) begin
            m_gray = gv;
            m_gchg = 1'b1;
        end
        m_pulse = m_bst && !m_bst_prev;
        if (m_pulse) m_show = !m_show;
        m_bst_prev = m_bst;
        bv = b_at(e - SS);
        b_stable = 1'b1;
        for (int j = 1; j <= DC; j++) if (b_at(e - SS - j) != bv) b_stable = 1'b0;
        if (b_stable) m_bst = bv;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(gray_raw, btn_raw);
        #1;
        pulse_cnt += int'(btn_pulse);
        gchg_cnt += int'(gray_changed);
        chk("model_gray_code", gray_code, m_gray);
        chk("model_gray_changed", gray_changed, m_gchg);
        chk("model_btn_pulse", btn_pulse, m_pulse);
        chk("model_show_decades", show_decades, m_show);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gray_code"}, gray_code, 0);
        chk({tag, "_show_decades"}, show_decades, 0);
        chk({tag, "_gray_changed"}, gray_changed, 0);
        chk({tag, "_btn_pulse"}, btn_pulse, 0);
    endtask

    // Asserted between edges so the outputs must clear without a clock.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("held_rst");
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] g;
        logic       b;
        logic [3:0] eg;
        logic       ec;
        logic       ep;
        logic       es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input logic [3:0] g, input logic b,
                                input logic [3:0] eg, input logic ec, input logic ep,
                                input logic es);
        vec_t v;
        v.rst = rst; v.g = g; v.b = b; v.eg = eg; v.ec = ec; v.ep = ep; v.es = es;
        return v;
    endfunction

    initial begin
        int pc0, gc0;

        // Row i is applied before edge i after reset; expectations hold after that edge.
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(i == 0, 4'b0110, 1'b1, (i >= 6) ? 4'b0110 : 4'b0000,
                             i == 6, 1'b0, 1'b0));
        for (int i = 0; i < 11; i++)
            tbl.push_back(mk(i == 0, (i < 3) ? 4'b0111 : 4'b0000, 1'b1, 4'b0000,
                             1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i == 0, (i < 2) ? 4'b0001 : 4'b0011, 1'b1,
                             (i >= 8) ? 4'b0011 : 4'b0000, i == 8, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i == 0, 4'b0000, 1'b0, 4'b0000, 1'b0, i == 7, i >= 7));

        #2;
        check_zero("por");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            gray_raw = tbl[i].g;
            btn_raw = tbl[i].b;
            tick();
            chk($sformatf("tbl%0d_gray_code", i), gray_code, tbl[i].eg);
            chk($sformatf("tbl%0d_gray_changed", i), gray_changed, tbl[i].ec);
            chk($sformatf("tbl%0d_btn_pulse", i), btn_pulse, tbl[i].ep);
            chk($sformatf("tbl%0d_show_decades", i), show_decades, tbl[i].es);
        end

        // Two long presses: one pulse each, select returns to 0.
        do_reset();
        gray_raw = 4'h0;
        pc0 = pulse_cnt;
        btn_raw = 1'b0; repeat (50) tick();
        btn_raw = 1'b1; repeat (15) tick();
        chk("press1_pulses", pulse_cnt - pc0, 1);
        chk("press1_show", show_decades, 1);
        btn_raw = 1'b0; repeat (50) tick();
        btn_raw = 1'b1; repeat (15) tick();
        chk("press2_pulses", pulse_cnt - pc0, 2);
        chk("press2_show", show_decades, 0);

        // Contact bounce every clock, then steady press.
        do_reset();
        pc0 = pulse_cnt;
        gc0 = gchg_cnt;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ~btn_raw;
            tick();
        end
        btn_raw = 1'b0; repeat (20) tick();
        chk("bounce_pulses", pulse_cnt - pc0, 1);
        chk("bounce_show", show_decades, 1);
        chk("bounce_no_gray_strobe", gchg_cnt - gc0, 0);

        // Reset during a gray count and a held press; full latency needed afterwards.
        do_reset();
        gray_raw = 4'b0110;
        btn_raw = 1'b0;
        repeat (12) tick();
        chk("pre_rst_gray", gray_code, 4'b0110);
        chk("pre_rst_show", show_decades, 1);
        gray_raw = 4'b1010;
        repeat (2) tick();
        do_reset();
        repeat (6) tick();
        chk("post_rst_gray_e5", gray_code, 4'b0000);
        chk("post_rst_pulse_e5", btn_pulse, 0);
        tick();
        chk("post_rst_gray_e6", gray_code, 4'b1010);
        chk("post_rst_gchg_e6", gray_changed, 1);
        tick();
        chk("post_rst_pulse_e7", btn_pulse, 1);
        chk("post_rst_show_e7", show_decades, 1);

        // Randomized segments of varying hold length, with occasional resets.
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 0) gray_raw = 4'($urandom);
            if ($urandom_range(0, 2) == 0) btn_raw = ~btn_raw;
            for (int k = 0; k < len; k++) tick();
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/module_input_conditioner.md
Name: module_input_conditioner

Overview:
- Upstream stage of the Gray decoder top; it feeds that top's gray_code and show_decades inputs.
- Synchronizes and debounces the 4 raw Gray-code switches and the raw pushbutton from the board.
- Delivers a clean 4-bit Gray code, a latched decades/units select that toggles once per confirmed press, and single-cycle event strobes.

Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive stable synchronized samples required before a new level is accepted (10 ms at 27 MHz). Legal range ≥2.
- SYNC_STAGES, 2: flip-flop depth of each synchronizer chain. Legal range ≥2.
- BTN_ACTIVE_LOW, 1: 1 means btn_raw reads 0 when pressed; 0 means btn_raw reads 1 when pressed.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- gray_raw  input  4  raw switch levels, asynchronous to clk.
- btn_raw  input  1  raw pushbutton level, asynchronous to clk.
- gray_code  output  4  debounced Gray code; drives the decoder top's gray_code input.
- show_decades  output  1  toggle-latched select; drives the decoder top's show_decades input.
- gray_changed  output  1  one-cycle strobe; high in the cycle gray_code takes a new value.
- btn_pulse  output  1  one-cycle strobe on each confirmed press.

Behaviour:
Clocking and reset
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- On assertion of rst_n, regardless of clock:
  - gray_code = 0, show_decades = 0, gray_changed = 0, btn_pulse = 0.
  - All counters = 0 and the FSM is in RELEASED.
  - Gray synchronizer and history registers = 0.
  - Button synchronizer and history registers = the inactive level (1 if BTN_ACTIVE_LOW, else 0).
- Reset mid-debounce discards the partial count; no strobe is emitted after release from reset.

Synchronizers
- gray_raw passes through a SYNC_STAGES flip-flop chain.
- btn_raw passes through a separate SYNC_STAGES flip-flop chain.
- The synchronized button is normalized to an internal pressed = 1 polarity per BTN_ACTIVE_LOW.

Debouncer (one instance for the 4-bit bus, one for the 1-bit button)
- s = synchronized sample; p = s delayed 1 clock; st = stable output register.
- Each edge: if s == st or s != p, then cnt <= 0.
- Otherwise, if cnt == DEBOUNCE_CYCLES-1: st <= s and cnt <= 0.
- Otherwise: cnt <= cnt+1.
- The bus is debounced as a whole: any bit change restarts the count, so intermediate multi-bit values are never emitted.
- Latency: a raw step held steady appears on st exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges after the first edge that samples it.
- A glitch shorter than that never reaches st.
- A return to the old st value mid-count clears cnt, with no output change.
- cnt width is clog2(DEBOUNCE_CYCLES); the counter saturates logically and never wraps.

Gray outputs
- gray_code = st of the bus debouncer.
- gray_changed is a registered strobe, high for exactly the one cycle in which gray_code holds its new value.

Button FSM (input = debounced button st)
- RELEASED -> PRESSED when st = 1. On that same edge: btn_pulse <= 1 for one cycle and show_decades <= ~show_decades.
- PRESSED -> RELEASED when st = 0, with no strobe.
- Holding the button produces exactly one toggle; the release produces no toggle.
- The button and bus paths are independent: simultaneous gray and button events each produce their own strobes in the same cycle.

Outputs
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All directed tests use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BTN_ACTIVE_LOW=1, btn_raw idle = 1.
1. Reset, then gray_raw 0000 -> 0110 held -> gray_code = 0110 exactly 7 edges after the first sampling edge; gray_changed high for 1 cycle; no earlier change.
2. gray_raw 0000 -> 0111 for 3 clocks -> back to 0000 -> gray_code stays 0000; gray_changed never asserts.
3. gray_raw steps 0001 -> 0011 after 2 clocks, then held -> gray_code goes directly 0000 -> 0011; 0001 never appears; one gray_changed strobe.
4. btn_raw = 0 held for 50 clocks, then 1 -> btn_pulse once; show_decades 0 -> 1. A second identical press returns show_decades to 0.
5. btn_raw bouncing 0/1 every clock for 20 clocks, then steady 0 -> exactly one btn_pulse; show_decades toggles once.
6. rst_n asserted mid-count, 2 clocks after a gray_raw change, and mid-press -> all outputs 0 immediately; after release the new levels need the full 7-edge latency again.
